// File: rtl/btn_press_classifier_pkg.sv
// Shared state encoding, event bundle and default timing for button classification.
// Also imported by the control FSM so both sides agree on state names.
package btn_press_classifier_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    typedef struct packed {
        logic press;
        logic short_p;
        logic dbl;
        logic long_p;
        logic rpt;
    } evt_t;

    localparam int DEF_CNT_W       = 26;
    localparam int DEF_LONG_CYC    = 50_000_000;
    localparam int DEF_DBL_GAP_CYC = 25_000_000;
    localparam int DEF_REPEAT_CYC  = 10_000_000;

endpackage

// File: rtl/btn_press_classifier_edge_det.sv
// Registers a debounced level and flags its rising and falling edges.
// Reusable for any other debounced input.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies debounced button activity into press, short, double, long and repeat events.
// All outputs are registered; one event pulse at most per cycle.
module btn_press_classifier
    import btn_press_classifier_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LONG_CYC    = DEF_LONG_CYC,
    parameter int DBL_GAP_CYC = DEF_DBL_GAP_CYC,
    parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_clean,
    output logic press_pulse,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam longint MAX_CYC = (longint'(1) << CNT_W) - 1;

    if (longint'(LONG_CYC) < 2 || longint'(LONG_CYC) > MAX_CYC ||
        longint'(DBL_GAP_CYC) < 2 || longint'(DBL_GAP_CYC) > MAX_CYC ||
        longint'(REPEAT_CYC) < 2 || longint'(REPEAT_CYC) > MAX_CYC) begin : g_bad_cfg
        $error("btn_press_classifier: timing parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYC - 1);

    logic rise;
    logic fall;

    btn_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_clean),
        .rise  (rise),
        .fall  (fall)
    );

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    evt_t             evt, evt_nx;
    logic             held_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            evt    <= '0;
            held_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            evt    <= evt_nx;
            held_q <= (state_nx == S_LONG);
        end
    end

    // Edge checks come before timer expiry so a coincident edge wins.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        evt_nx   = '0;
        unique case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (rise) begin
                    state_nx     = S_PRESS1;
                    evt_nx.press = 1'b1;
                end
            end
            S_PRESS1: begin
                if (fall) begin
                    state_nx = S_WAIT2;
                    cnt_nx   = '0;
                end else if (cnt == LONG_END) begin
                    state_nx      = S_LONG;
                    cnt_nx        = '0;
                    evt_nx.long_p = 1'b1;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_nx     = S_PRESS2;
                    cnt_nx       = '0;
                    evt_nx.press = 1'b1;
                end else if (cnt == GAP_END) begin
                    state_nx       = S_IDLE;
                    cnt_nx         = '0;
                    evt_nx.short_p = 1'b1;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_nx   = S_IDLE;
                    cnt_nx     = '0;
                    evt_nx.dbl = 1'b1;
                end else if (cnt == LONG_END) begin
                    state_nx      = S_LONG;
                    cnt_nx        = '0;
                    evt_nx.long_p = 1'b1;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == REP_END) begin
                    cnt_nx     = '0;
                    evt_nx.rpt = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign press_pulse  = evt.press;
    assign short_press  = evt.short_p;
    assign double_click = evt.dbl;
    assign long_press   = evt.long_p;
    assign repeat_pulse = evt.rpt;
    assign held         = held_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed scenarios for btn_press_classifier with short timing parameters.
// Pulse timestamps are cycles after the first edge of each scenario.
module tb_btn_press_classifier;
    import btn_press_classifier_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_clean = 1'b0;
    logic press_pulse, short_press, double_click;
    logic long_press, repeat_pulse, held;

    btn_press_classifier #(
        .CNT_W       (8),
        .LONG_CYC    (8),
        .DBL_GAP_CYC (6),
        .REPEAT_CYC  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_clean    (btn_clean),
        .press_pulse  (press_pulse),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc;
    int n_press, n_short, n_dbl, n_long, n_rep, n_held, n_multi;
    int t_press, t_short, t_dbl, t_long, t_rep_first, t_rep_last;

    task automatic clear_log();
        cyc = 0;
        n_press = 0; n_short = 0; n_dbl = 0; n_long = 0;
        n_rep = 0; n_held = 0; n_multi = 0;
        t_press = -1; t_short = -1; t_dbl = -1; t_long = -1;
        t_rep_first = -1; t_rep_last = -1;
    endtask

    // One clock with btn_clean = b, then log whatever the registers show.
    task automatic step(input logic b);
        int k;
        btn_clean = b;
        @(posedge clk);
        #1;
        cyc++;
        k = int'(press_pulse) + int'(short_press) + int'(double_click)
          + int'(long_press) + int'(repeat_pulse);
        if (k > 1) n_multi++;
        if (press_pulse)  begin n_press++; t_press = cyc; end
        if (short_press)  begin n_short++; t_short = cyc; end
        if (double_click) begin n_dbl++;   t_dbl   = cyc; end
        if (long_press)   begin n_long++;  t_long  = cyc; end
        if (repeat_pulse) begin
            n_rep++;
            if (t_rep_first < 0) t_rep_first = cyc;
            t_rep_last = cyc;
        end
        if (held) n_held++;
    endtask

    task automatic steps(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(1'b0, 2);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        steps(1'b0, 3);
        checks++;
        if ({press_pulse, short_press, double_click, long_press, repeat_pulse, held} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {press_pulse, short_press, double_click, long_press, repeat_pulse, held});
        end
        rst = 1'b0;
    endtask

    task automatic test_short();
        do_reset();
        steps(1'b1, 3);
        steps(1'b0, 12);
        checks++; if (n_press !== 1) begin fails++; $display("FAIL short_npress: got %0d want 1", n_press); end
        checks++; if (t_press !== 1) begin fails++; $display("FAIL short_tpress: got %0d want 1", t_press); end
        checks++; if (t_short !== 10) begin fails++; $display("FAIL short_time: got %0d want 10", t_short); end
        checks++; if (n_short !== 1) begin fails++; $display("FAIL short_count: got %0d want 1", n_short); end
        checks++;
        if (n_dbl + n_long + n_rep + n_held !== 0) begin
            fails++;
            $display("FAIL short_others: got %0d want 0", n_dbl + n_long + n_rep + n_held);
        end
    endtask

    task automatic test_double();
        do_reset();
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 3);
        steps(1'b0, 10);
        checks++; if (n_press !== 2) begin fails++; $display("FAIL dbl_npress: got %0d want 2", n_press); end
        checks++; if (t_press !== 6) begin fails++; $display("FAIL dbl_tpress: got %0d want 6", t_press); end
        checks++; if (t_dbl !== 9) begin fails++; $display("FAIL dbl_time: got %0d want 9", t_dbl); end
        checks++; if (n_dbl !== 1) begin fails++; $display("FAIL dbl_count: got %0d want 1", n_dbl); end
        checks++; if (n_short !== 0) begin fails++; $display("FAIL dbl_noshort: got %0d want 0", n_short); end
    endtask

    task automatic test_long_hold();
        do_reset();
        steps(1'b1, 22);
        checks++; if (held !== 1'b1) begin fails++; $display("FAIL long_held_on: got %b want 1", held); end
        steps(1'b0, 6);
        checks++; if (t_long !== 9) begin fails++; $display("FAIL long_time: got %0d want 9", t_long); end
        checks++; if (n_long !== 1) begin fails++; $display("FAIL long_count: got %0d want 1", n_long); end
        checks++; if (n_rep !== 3) begin fails++; $display("FAIL rep_count: got %0d want 3", n_rep); end
        checks++; if (t_rep_first !== 13) begin fails++; $display("FAIL rep_first: got %0d want 13", t_rep_first); end
        checks++; if (t_rep_last !== 21) begin fails++; $display("FAIL rep_last: got %0d want 21", t_rep_last); end
        checks++; if (n_held !== 14) begin fails++; $display("FAIL held_cycles: got %0d want 14", n_held); end
        checks++; if (held !== 1'b0) begin fails++; $display("FAIL long_held_off: got %b want 0", held); end
    endtask

    task automatic test_second_long();
        do_reset();
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 10);
        steps(1'b0, 5);
        checks++; if (n_press !== 2) begin fails++; $display("FAIL p2long_npress: got %0d want 2", n_press); end
        checks++; if (t_long !== 14) begin fails++; $display("FAIL p2long_time: got %0d want 14", t_long); end
        checks++; if (n_dbl !== 0) begin fails++; $display("FAIL p2long_nodbl: got %0d want 0", n_dbl); end
        checks++; if (n_short !== 0) begin fails++; $display("FAIL p2long_noshort: got %0d want 0", n_short); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 2);
        rst = 1'b1;
        step(1'b0);
        checks++;
        if ({press_pulse, short_press, double_click, long_press, repeat_pulse, held} !== 6'b0) begin
            fails++;
            $display("FAIL rst_abort_out: got %b want 000000",
                     {press_pulse, short_press, double_click, long_press, repeat_pulse, held});
        end
        checks++;
        if (dut.state !== S_IDLE) begin
            fails++;
            $display("FAIL rst_abort_state: got %0d want %0d", dut.state, S_IDLE);
        end
        step(1'b1);
        rst = 1'b0;
        clear_log();
        step(1'b1);
        checks++; if (press_pulse !== 1'b1) begin fails++; $display("FAIL rst_held_press: got %b want 1", press_pulse); end
        steps(1'b0, 10);
        checks++; if (n_dbl !== 0) begin fails++; $display("FAIL rst_nodbl: got %0d want 0", n_dbl); end
    endtask

    task automatic test_coincident_rise();
        do_reset();
        steps(1'b1, 3);
        steps(1'b0, 6);
        steps(1'b1, 3);
        steps(1'b0, 10);
        checks++; if (n_short !== 0) begin fails++; $display("FAIL coin_noshort: got %0d want 0", n_short); end
        checks++; if (t_press !== 10) begin fails++; $display("FAIL coin_tpress: got %0d want 10", t_press); end
        checks++; if (t_dbl !== 13) begin fails++; $display("FAIL coin_dbl: got %0d want 13", t_dbl); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 3);
        steps(1'b0, 2);
        steps(1'b1, 3);
        steps(1'b0, 12);
        checks++; if (n_press !== 3) begin fails++; $display("FAIL triple_npress: got %0d want 3", n_press); end
        checks++; if (n_dbl !== 1) begin fails++; $display("FAIL triple_ndbl: got %0d want 1", n_dbl); end
        checks++; if (t_dbl !== 9) begin fails++; $display("FAIL triple_tdbl: got %0d want 9", t_dbl); end
        checks++; if (t_short !== 20) begin fails++; $display("FAIL triple_tshort: got %0d want 20", t_short); end
        checks++; if (n_multi !== 0) begin fails++; $display("FAIL one_pulse_per_cycle: got %0d want 0", n_multi); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_short();
        test_double();
        test_long_hold();
        test_second_long();
        test_reset_abort();
        test_coincident_rise();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
